fir_decim_avg: RTL and testbench
================================

FIR_DECIM_AVG -- requirements
Module: fir_decim_avg

Interface
REQ-001 SHALL have parameter DIN_W, default 32, meaning the width of the signed filtered sample input.
REQ-002 SHALL have parameter LOG2_DEC, default 4, meaning log2 of the decimation ratio; the block averages 2^LOG2_DEC samples; legal range 1..8.
REQ-003 SHALL have parameter TRIG_DLY, default 3, meaning the number of clk cycles from i_trig to valid din; legal range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_trig, input, 1 bit: sample strobe, the same strobe that drives the upstream FIR gate.
REQ-007 SHALL have port din, input, DIN_W bits, signed: filtered FIR output.
REQ-008 SHALL have port i_clear, input, 1 bit: synchronous clear of the window, output, and flags.
REQ-009 SHALL have port o_data, output, DIN_W bits, signed: averaged sample.
REQ-010 SHALL have port o_valid, output, 1 bit: o_data holds an unconsumed result.
REQ-011 SHALL have port i_ready, input, 1 bit: consumer accepts o_data when o_valid and i_ready are both high.
REQ-012 SHALL have port o_overrun, output, 1 bit: sticky flag, a completed result was dropped.
REQ-013 SHALL have port o_cnt, output, LOG2_DEC bits: number of samples in the current window.

Function
REQ-014 SHALL delay i_trig through a TRIG_DLY-stage shift register to form the capture strobe cap; if TRIG_DLY=0, cap=i_trig.
REQ-015 SHALL, on each clk edge where cap=1, add sign-extended din to a DIN_W+LOG2_DEC-bit accumulator, and increment o_cnt.
REQ-016 SHALL count every capture, including captures on back-to-back cycles.
REQ-017 SHALL treat the capture where o_cnt = 2^LOG2_DEC-1 as the window-end capture.
REQ-018 At the window-end capture, SHALL compute result = (acc + din) >>> LOG2_DEC (arithmetic shift, floor rounding, no saturation needed), then clear acc and o_cnt to 0 on the same edge.
REQ-019 At the window-end capture, if o_valid=0 or (o_valid and i_ready), SHALL register the result into o_data and set o_valid=1 on that edge, giving a latency of 1 cycle after the last capture edge.
REQ-020 At the window-end capture, if o_valid=1 and i_ready=0, SHALL drop the result, keep o_data and o_valid unchanged, and set o_overrun=1.
REQ-021 SHALL hold o_data stable while o_valid=1 and i_ready=0.
REQ-022 SHALL clear o_valid on a handshake edge with no new result loaded.
REQ-023 SHALL keep o_overrun set until i_clear or reset.
REQ-024 While i_clear=1, SHALL clear acc, o_cnt, the delay line, o_valid, and o_overrun; i_clear wins over a simultaneous capture (the sample is discarded) and over a simultaneous window end.
REQ-025 SHALL leave o_data unchanged on i_clear.
REQ-026 SHALL use two states: ACC (o_valid=0) and HOLD (o_valid=1).
REQ-027 ACC->HOLD SHALL occur on a loaded result; HOLD->ACC on a handshake without a new result; HOLD->HOLD on a handshake with a simultaneous new result; any state->ACC on i_clear.

Reset
REQ-028 While n_rst=0, SHALL asynchronously force o_data=0, o_valid=0, o_overrun=0, o_cnt=0, acc=0, delay line=0.
REQ-029 SHALL discard a partial window on reset; after reset release, the first capture starts a new window.

Verification (LOG2_DEC=2, TRIG_DLY=3, DIN_W=32)
REQ-030 Bench SHALL cover: din=100 constant, 4 i_trig pulses, i_ready=1 -> o_valid high 1 cycle, o_data=100, 4 cycles after the 4th i_trig.
REQ-031 Bench SHALL cover: samples -3,-3,-3,-2 -> o_data=-3 (sum -11, floor rounding).
REQ-032 Bench SHALL cover: i_ready=0, 8 captures of 5 then 8 captures of 9 -> o_data=5 held, o_valid=1, o_overrun=1; then i_ready=1 for 1 cycle -> o_valid=0.
REQ-033 Bench SHALL cover: 4 captures of 0x7FFFFFFF, then 4 of 0x80000000 -> o_data=0x7FFFFFFF, then 0x80000000, with no wrap.
REQ-034 Bench SHALL cover: 2 captures of 50, i_clear, 4 captures of 8 -> o_data=8 and o_cnt=0 after the clear.
REQ-035 Bench SHALL cover: n_rst asserted after 3 captures, then 4 captures of 7 -> o_data=7; all outputs 0 during reset.

Source files
------------

// File: rtl/fir_decim_avg.sv
// Decimating boxcar averager for the FIR output: sums 2^LOG2_DEC captured samples
// and presents the floor-rounded mean on a valid/ready output with a sticky overrun flag.
module fir_decim_avg #(
  parameter int unsigned DIN_W    = 32,
  parameter int unsigned LOG2_DEC = 4,
  parameter int unsigned TRIG_DLY = 3
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_trig,
  input  logic signed [DIN_W-1:0]    din,
  input  logic                       i_clear,
  output logic signed [DIN_W-1:0]    o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_overrun,
  output logic [LOG2_DEC-1:0]        o_cnt
);

  localparam int unsigned ACC_W = DIN_W + LOG2_DEC;
  localparam logic [LOG2_DEC-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  logic cap;

  // Align i_trig with the upstream FIR latency so cap marks the cycle din is valid.
  generate
    if (TRIG_DLY == 0) begin : g_nodly
      assign cap = i_trig;
    end else begin : g_dly
      logic [TRIG_DLY-1:0] dly_q;
      logic [TRIG_DLY-1:0] dly_d;

      always_comb begin
        dly_d = (dly_q << 1) | TRIG_DLY'(i_trig);
        if (i_clear) begin
          dly_d = '0;
        end
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          dly_q <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign cap = dly_q[TRIG_DLY-1];
    end
  endgenerate

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [LOG2_DEC-1:0]       cnt_q, cnt_d;
  logic signed [DIN_W-1:0]   data_q, data_d;
  logic                      ovr_q, ovr_d;

  logic signed [ACC_W-1:0]   din_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      win_end;
  logic                      handshake;
  logic                      load;

  // Accumulator is wide enough for 2^LOG2_DEC full-scale samples, so no wrap.
  assign din_ext   = ACC_W'(din);
  assign sum       = acc_q + din_ext;
  assign win_end   = cap && (cnt_q == CNT_MAX);
  assign handshake = (state_q == ST_HOLD) && i_ready;
  assign load      = win_end && ((state_q == ST_ACC) || i_ready);

  // Next-state: window accumulation, result load/drop, handshake; clear wins over all.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ovr_d   = ovr_q;

    if (i_clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      if (cap) begin
        if (win_end) begin
          acc_d = '0;
          cnt_d = '0;
          if (!load) begin
            ovr_d = 1'b1;
          end
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + LOG2_DEC'(1);
        end
      end

      if (load) begin
        data_d  = DIN_W'(sum >>> LOG2_DEC);
        state_d = ST_HOLD;
      end else if (handshake) begin
        state_d = ST_ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = (state_q == ST_HOLD);
  assign o_overrun = ovr_q;
  assign o_cnt     = cnt_q;

endmodule

// File: tb/tb_fir_decim_avg.sv
// Directed bench for fir_decim_avg (4-sample windows, 3-cycle trigger delay) with a
// result scoreboard filled as windows are driven and drained as results appear.
module tb_fir_decim_avg;

  localparam int unsigned DIN_W    = 32;
  localparam int unsigned LOG2_DEC = 2;
  localparam int unsigned TRIG_DLY = 3;

  logic                     clk = 1'b0;
  logic                     n_rst;
  logic                     i_trig;
  logic signed [DIN_W-1:0]  din;
  logic                     i_clear;
  logic signed [DIN_W-1:0]  o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_overrun;
  logic [LOG2_DEC-1:0]      o_cnt;

  int checks   = 0;
  int failures = 0;
  logic signed [DIN_W-1:0] exp_q[$];

  fir_decim_avg #(
    .DIN_W    (DIN_W),
    .LOG2_DEC (LOG2_DEC),
    .TRIG_DLY (TRIG_DLY)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_trig    (i_trig),
    .din       (din),
    .i_clear   (i_clear),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_overrun (o_overrun),
    .o_cnt     (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n back-to-back triggers with din held until the last delayed capture has happened.
  task automatic burst(input int n, input logic [DIN_W-1:0] v);
    din    = v;
    i_trig = 1'b1;
    repeat (n) @(negedge clk);
    i_trig = 1'b0;
    repeat (TRIG_DLY) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int max_wait);
    int w = 0;
    logic signed [DIN_W-1:0] e;
    while (!o_valid && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, 64'(o_valid), 64'(1));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty_queue expected=pending_result", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 64'(o_data), 64'(e));
    end
  endtask

  initial begin
    n_rst   = 1'b0;
    i_trig  = 1'b0;
    din     = '0;
    i_clear = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data",    64'(o_data),    64'(0));
    check("rst_valid",   64'(o_valid),   64'(0));
    check("rst_overrun", 64'(o_overrun), 64'(0));
    check("rst_cnt",     64'(o_cnt),     64'(0));
    n_rst = 1'b1;
    @(negedge clk);

    // Constant 100, result one cycle after the last capture, valid for one cycle.
    repeat (3) burst(1, 100);
    check("t1_cnt3", 64'(o_cnt), 64'(3));
    exp_q.push_back(100);
    burst(1, 100);
    expect_out("t1", 0);
    @(negedge clk);
    check("t1_valid_1cyc", 64'(o_valid), 64'(0));
    check("t1_cnt0",       64'(o_cnt),   64'(0));

    // Floor rounding of a negative mean: -11/4 -> -3.
    repeat (3) burst(1, -3);
    exp_q.push_back(-3);
    burst(1, -2);
    expect_out("t2", 0);
    @(negedge clk);

    // Stalled consumer: first result held, later windows dropped, overrun sticky.
    i_ready = 1'b0;
    exp_q.push_back(5);
    burst(8, 5);
    burst(8, 9);
    expect_out("t3", 0);
    check("t3_overrun", 64'(o_overrun), 64'(1));
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("t3_valid_after_hs",  64'(o_valid),   64'(0));
    check("t3_overrun_sticky",  64'(o_overrun), 64'(1));
    i_ready = 1'b1;

    // Full-scale extremes average without wrapping.
    exp_q.push_back(32'h7FFF_FFFF);
    burst(4, 32'h7FFF_FFFF);
    expect_out("t4_max", 0);
    exp_q.push_back(32'h8000_0000);
    burst(4, 32'h8000_0000);
    expect_out("t4_min", 0);

    // Clear discards a partial window and the overrun flag but keeps o_data.
    burst(2, 50);
    check("t5_cnt2", 64'(o_cnt), 64'(2));
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    check("t5_cnt_clr",     64'(o_cnt),     64'(0));
    check("t5_overrun_clr", 64'(o_overrun), 64'(0));
    check("t5_valid_clr",   64'(o_valid),   64'(0));
    check("t5_data_kept",   64'(o_data),    64'(32'sh8000_0000));

    // Clear coincident with a capture drops that sample.
    din    = 77;
    i_trig = 1'b1;
    @(negedge clk);
    i_trig = 1'b0;
    repeat (2) @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    check("t5_cap_vs_clr", 64'(o_cnt), 64'(0));
    exp_q.push_back(8);
    burst(4, 8);
    expect_out("t5", 0);
    @(negedge clk);

    // Asynchronous reset mid-window; the next window starts fresh.
    burst(3, 11);
    check("t6_cnt3", 64'(o_cnt), 64'(3));
    n_rst = 1'b0;
    #1;
    check("t6_rst_data",    64'(o_data),    64'(0));
    check("t6_rst_valid",   64'(o_valid),   64'(0));
    check("t6_rst_overrun", 64'(o_overrun), 64'(0));
    check("t6_rst_cnt",     64'(o_cnt),     64'(0));
    @(negedge clk);
    n_rst = 1'b1;
    exp_q.push_back(7);
    burst(4, 7);
    expect_out("t6", 0);
    @(negedge clk);
    check("t6_valid_done", 64'(o_valid), 64'(0));
    check("t6_cnt0",       64'(o_cnt),   64'(0));

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
